sipo_collector: RTL and testbench

Serial-in, parallel-out collector that sits directly downstream of the serial shift chain. It samples one bit per enabled clock from the chain output, assembles WIDTH-bit words, and presents each word on a parallel port. A one-deep output holding register with a valid/ready handshake lets collection continue while the consumer stalls. Overflow is reported through a sticky overrun flag.

---
 rtl/sipo_collector.sv | 95 +++++++++
 tb/tb_sipo_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_collector.sv
// Serial-in, parallel-out word collector with a one-deep valid/ready output
// register and a sticky overrun flag for words dropped under backpressure.
module sipo_collector #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             shift_en,
    input  logic             sync,
    input  logic             pready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt_eff;
    logic [CW-1:0]    pos;
    logic             complete;
    logic             load;
    logic             drop;

    // A sync on the same edge as a sample restarts the word at position 0.
    always_comb begin
        cnt_eff  = sync ? '0 : bit_cnt;
        pos      = (LSB_FIRST != 0) ? cnt_eff : CW'(WIDTH - 1) - cnt_eff;
        word     = shreg;
        word[pos] = sin;
        complete = shift_en && !sync && (bit_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (pready)
                        load = 1'b1;
                    else
                        drop = 1'b1;
                end else if (pready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            pout    <= '0;
            overrun <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (shift_en)
                shreg <= word;
            if (load)
                pout <= word;
            // A drop on the same edge as a clear keeps the flag set.
            overrun <= drop | (overrun & ~ovr_clr);
            if (sync)
                bit_cnt <= shift_en ? CW'(1) : '0;
            else if (shift_en)
                bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        end
    end

    assign pvalid = (state == FULL);

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector: an LSB-first and an MSB-first instance share one
// stimulus stream and are checked every cycle against a bit-queue model.
module tb_sipo_collector;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sin = 1'b0;
    logic         shift_en = 1'b0;
    logic         sync = 1'b0;
    logic         pready = 1'b0;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] pout_l, pout_m;
    logic         pvalid_l, pvalid_m, overrun_l, overrun_m;
    logic [1:0]   bit_cnt_l, bit_cnt_m;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    sipo_collector #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
        .clk(clk), .reset(reset), .sin(sin), .shift_en(shift_en), .sync(sync),
        .pready(pready), .ovr_clr(ovr_clr), .pout(pout_l), .pvalid(pvalid_l),
        .overrun(overrun_l), .bit_cnt(bit_cnt_l)
    );

    sipo_collector #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
        .clk(clk), .reset(reset), .sin(sin), .shift_en(shift_en), .sync(sync),
        .pready(pready), .ovr_clr(ovr_clr), .pout(pout_m), .pvalid(pvalid_m),
        .overrun(overrun_m), .bit_cnt(bit_cnt_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Model: the bits of the current partial word, in arrival order.
    bit       bits[$];
    bit       m_valid = 1'b0;
    bit       m_ovr = 1'b0;
    int       m_pout_l = 0;
    int       m_pout_m = 0;

    always @(posedge clk) begin
        bit done, dropped;
        int vl, vm;
        done = 1'b0;
        dropped = 1'b0;
        vl = 0;
        vm = 0;
        if (reset) begin
            bits.delete();
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_pout_l = 0;
            m_pout_m = 0;
        end else begin
            if (sync)
                bits.delete();
            if (shift_en) begin
                bits.push_back(sin);
                if (bits.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        vl += int'(bits[i]) << i;
                        vm += int'(bits[i]) << (W - 1 - i);
                    end
                    bits.delete();
                end
            end
            if (done && (!m_valid || pready)) begin
                m_pout_l = vl;
                m_pout_m = vm;
                m_valid = 1'b1;
            end else if (done) begin
                dropped = 1'b1;
            end else if (m_valid && pready) begin
                m_valid = 1'b0;
            end
            m_ovr = dropped ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pout_l", 32'(pout_l), 32'(m_pout_l));
            chk("pout_m", 32'(pout_m), 32'(m_pout_m));
            chk("pvalid_l", 32'(pvalid_l), 32'(m_valid));
            chk("pvalid_m", 32'(pvalid_m), 32'(m_valid));
            chk("overrun_l", 32'(overrun_l), 32'(m_ovr));
            chk("overrun_m", 32'(overrun_m), 32'(m_ovr));
            chk("bit_cnt_l", 32'(bit_cnt_l), 32'(bits.size()));
            chk("bit_cnt_m", 32'(bit_cnt_m), 32'(bits.size()));
        end
    end

    task automatic cyc(input logic s, input logic en, input logic sy, input logic pr, input logic oc);
        sin = s;
        shift_en = en;
        sync = sy;
        pready = pr;
        ovr_clr = oc;
        @(posedge clk);
        #1;
    endtask

    // b[0] is sent first; pready is pr_early for the first three bits.
    task automatic send4(input logic [3:0] b, input logic pr_early, input logic pr_last, input logic oc_last);
        for (int i = 0; i < 4; i++)
            cyc(b[i], 1'b1, 1'b0, (i == 3) ? pr_last : pr_early, (i == 3) ? oc_last : 1'b0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_pout", 32'(pout_l), 32'h0);
        chk("rst_pvalid", 32'(pvalid_l), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt_l), 32'h0);

        // LSB-first word, pready held high
        cyc(1, 1, 0, 1, 0); chk("t1_cnt1", 32'(bit_cnt_l), 32'd1);
        cyc(0, 1, 0, 1, 0); chk("t1_cnt2", 32'(bit_cnt_l), 32'd2);
        cyc(1, 1, 0, 1, 0); chk("t1_cnt3", 32'(bit_cnt_l), 32'd3);
        cyc(0, 1, 0, 1, 0); chk("t1_cnt0", 32'(bit_cnt_l), 32'd0);
        chk("t1_pout_l", 32'(pout_l), 32'h5);
        chk("t1_pout_m", 32'(pout_m), 32'hA);
        chk("t1_pvalid", 32'(pvalid_l), 32'h1);
        cyc(0, 0, 0, 1, 0); chk("t1_pvalid_drop", 32'(pvalid_l), 32'h0);

        // MSB-first word, then a gapped word
        send4(4'b1101, 1'b1, 1'b1, 1'b0);
        chk("t2_pout_m", 32'(pout_m), 32'hB);
        cyc(0, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0); chk("t2_hold", 32'(bit_cnt_m), 32'd1);
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0); chk("t2_hold2", 32'(bit_cnt_m), 32'd2);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        chk("t2_pout_m_gap", 32'(pout_m), 32'h6);
        chk("t2_pvalid", 32'(pvalid_m), 32'h1);

        // Backpressure and overrun
        cyc(0, 0, 0, 1, 0);
        send4(4'b0101, 1'b0, 1'b0, 1'b0);
        chk("t3_w1_pout", 32'(pout_l), 32'h5);
        chk("t3_w1_pvalid", 32'(pvalid_l), 32'h1);
        send4(4'b0011, 1'b0, 1'b0, 1'b0);
        chk("t3_w2_ovr", 32'(overrun_l), 32'h1);
        chk("t3_w2_pout", 32'(pout_l), 32'h5);
        cyc(0, 0, 0, 1, 0); chk("t3_xfer", 32'(pvalid_l), 32'h0);
        send4(4'b1001, 1'b0, 1'b0, 1'b0);
        chk("t3_w3_pout", 32'(pout_l), 32'h9);
        chk("t3_w3_pvalid", 32'(pvalid_l), 32'h1);
        send4(4'b0110, 1'b0, 1'b0, 1'b1);
        chk("t3_setwins", 32'(overrun_l), 32'h1);
        chk("t3_setwins_pout", 32'(pout_l), 32'h9);
        cyc(0, 0, 0, 0, 1); chk("t3_clr", 32'(overrun_l), 32'h0);

        // Transfer and completion on the same edge
        cyc(0, 0, 0, 1, 0);
        send4(4'b0101, 1'b0, 1'b0, 1'b0);
        send4(4'b1010, 1'b0, 1'b1, 1'b0);
        chk("t4_pout", 32'(pout_l), 32'hA);
        chk("t4_pvalid", 32'(pvalid_l), 32'h1);
        chk("t4_ovr", 32'(overrun_l), 32'h0);

        // Mid-word sync
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0); chk("t5_cnt2", 32'(bit_cnt_l), 32'd2);
        cyc(0, 1, 1, 0, 0); chk("t5_sync_cnt", 32'(bit_cnt_l), 32'd1);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); chk("t5_no_glitch", 32'(pvalid_l), 32'h0);
        cyc(1, 1, 0, 0, 0);
        chk("t5_pout_l", 32'(pout_l), 32'hA);
        chk("t5_pout_m", 32'(pout_m), 32'h5);

        // Reset mid-operation
        cyc(0, 0, 0, 1, 0);
        send4(4'b0101, 1'b0, 1'b0, 1'b0);
        send4(4'b0011, 1'b0, 1'b0, 1'b0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t6_pre_ovr", 32'(overrun_l), 32'h1);
        chk("t6_pre_cnt", 32'(bit_cnt_l), 32'd2);
        reset = 1'b1;
        cyc(1, 1, 0, 1, 0);
        reset = 1'b0;
        chk("t6_pout", 32'(pout_l), 32'h0);
        chk("t6_pvalid", 32'(pvalid_l), 32'h0);
        chk("t6_ovr", 32'(overrun_l), 32'h0);
        chk("t6_cnt", 32'(bit_cnt_l), 32'h0);
        send4(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("t6_pout_l", 32'(pout_l), 32'hF);
        chk("t6_pout_m", 32'(pout_m), 32'hF);

        cyc(0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
